alarm_event_ctrl: RTL

ALARM_EVENT_CTRL -- requirements
Module: alarm_event_ctrl

---
 rtl/alarm_event_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_event_ctrl.sv
// alarm_event_ctrl: debounces three active-low alarm sensors and sequences the
// alarm through IDLE -> ALARM -> HOLDOFF. It emits a single-cycle jingbao pulse
// each time a new sensor source becomes active.
//
// Ports:
//   clk_24m      in   system clock (24 MHz)
//   rst_n        in   asynchronous active-low reset
//   yan_en       in   smoke sensor, active-low, asynchronous
//   qi_en        in   gas sensor, active-low, asynchronous
//   huo_en       in   flame sensor, active-low, asynchronous
//   ack          in   synchronous acknowledge, level sampled every cycle
//   jingbao      out  single-cycle alarm pulse
//   alarm_code   out  latched active sources {huo, qi, yan}
//   alarm_active out  high while in ALARM
//   holdoff      out  high while in HOLDOFF
module alarm_event_ctrl #(
  parameter int unsigned DEB_CYCLES     = 240000,
  parameter int unsigned HOLDOFF_CYCLES = 24000000
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic       yan_en,
  input  logic       qi_en,
  input  logic       huo_en,
  input  logic       ack,
  output logic       jingbao,
  output logic [2:0] alarm_code,
  output logic       alarm_active,
  output logic       holdoff
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned DEB_W  = 20;
  localparam int unsigned HOLD_W = 25;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALARM   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // Channel bit order matches alarm_code: [2]=huo, [1]=qi, [0]=yan.
  logic [NCH-1:0]    w_pad;
  logic [NCH-1:0]    r_sync1;
  logic [NCH-1:0]    r_sync2;
  logic [NCH-1:0]    r_f;
  logic [NCH-1:0]    r_f_d;
  logic [DEB_W-1:0]  r_deb_cnt [NCH];
  logic [NCH-1:0]    w_ev;
  logic [NCH-1:0]    w_new_ev;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NCH-1:0]    r_code;
  logic [NCH-1:0]    w_code_nxt;
  logic [HOLD_W-1:0] r_hcnt;
  logic [HOLD_W-1:0] w_hcnt_nxt;
  logic              r_jingbao;
  logic              w_jb_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic              r_alarm_active;
  logic              r_holdoff;

  assign w_pad = {huo_en, qi_en, yan_en};

  // Two-flop synchroniser; idle level of the pads is high.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_pad;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce: f follows s only after DEB_CYCLES consecutive mismatches.
  for (genvar g = 0; g < NCH; g++) begin : g_deb
    always_ff @(posedge clk_24m or negedge rst_n) begin
      if (!rst_n) begin
        r_deb_cnt[g] <= '0;
        r_f[g]       <= 1'b1;
      end else if (r_sync2[g] == r_f[g]) begin
        r_deb_cnt[g] <= '0;
      end else if (r_deb_cnt[g] == DEB_LAST) begin
        r_f[g]       <= r_sync2[g];
        r_deb_cnt[g] <= '0;
      end else begin
        r_deb_cnt[g] <= r_deb_cnt[g] + DEB_W'(1);
      end
    end
  end

  // Delayed copy of f; an event is a registered 1->0 edge of f.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_f_d <= '1;
    end else begin
      r_f_d <= r_f;
    end
  end

  assign w_ev     = r_f_d & ~r_f;
  assign w_new_ev = w_ev & ~r_code;

  // State and output registers.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_code         <= '0;
      r_hcnt         <= '0;
      r_jingbao      <= 1'b0;
      r_pend         <= 1'b0;
      r_alarm_active <= 1'b0;
      r_holdoff      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_code         <= w_code_nxt;
      r_hcnt         <= w_hcnt_nxt;
      r_jingbao      <= w_jb_nxt;
      r_pend         <= w_pend_nxt;
      r_alarm_active <= (w_state_nxt == S_ALARM);
      r_holdoff      <= (w_state_nxt == S_HOLDOFF);
    end
  end

  // Next-state and next-output logic.
  // r_pend defers a pulse by one cycle when a new source arrives right after a
  // pulse, so jingbao is never high on two consecutive cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_hcnt_nxt  = r_hcnt;
    w_jb_nxt    = 1'b0;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (|w_ev) begin
          w_state_nxt = S_ALARM;
          w_code_nxt  = w_ev;
          w_jb_nxt    = 1'b1;
          w_pend_nxt  = 1'b0;
        end
      end
      S_ALARM: begin
        if (ack) begin
          w_state_nxt = S_HOLDOFF;
          w_code_nxt  = '0;
          w_hcnt_nxt  = '0;
          w_pend_nxt  = 1'b0;
        end else begin
          w_code_nxt = r_code | w_new_ev;
          if ((|w_new_ev) || r_pend) begin
            if (r_jingbao) begin
              w_pend_nxt = 1'b1;
            end else begin
              w_jb_nxt   = 1'b1;
              w_pend_nxt = 1'b0;
            end
          end
        end
      end
      S_HOLDOFF: begin
        w_hcnt_nxt = r_hcnt + HOLD_W'(1);
        if (r_hcnt == HOLD_LAST) begin
          w_hcnt_nxt = '0;
          if (~&r_f) begin
            w_state_nxt = S_ALARM;
            w_code_nxt  = ~r_f;
            w_jb_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = '0;
        w_hcnt_nxt  = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  assign jingbao      = r_jingbao;
  assign alarm_code   = r_code;
  assign alarm_active = r_alarm_active;
  assign holdoff      = r_holdoff;

endmodule
